// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronises the raw ps2_clk/ps2_dat pins, glitch-filters the clock,
// deserialises start/8 data/odd parity/stop frames and aborts stalled
// frames with an inter-edge watchdog.
// Optional build macro: PS2_PARITY_CHECK_EN (enables the odd-parity check at STOP).
//
// state  | meaning
// -------+---------------------------------------------------
// IDLE   | waiting for a start bit (dat=0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop (and parity), delivering the byte

module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       key_en,
    output logic [7:0] key_data,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk, filt_clk_q;
    logic          fall;

    state_t        state, state_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic [7:0]    key_data_nxt;
    logic          key_en_nxt, frame_err_nxt;
    logic          stop_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic          par, par_nxt;
    assign stop_ok = dat_sync & (^{shreg, par});
`else
    assign stop_ok = dat_sync;
`endif

    // two-flop synchronisers on both pins; idle level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    // filtered clock follows the synced clock only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt   <= FILT_LOAD;
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
        end else begin
            filt_clk_q <= filt_clk;
            if (clk_sync == filt_clk) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                filt_clk <= clk_sync;
                filt_cnt <= FILT_LOAD;
            end else begin
                filt_cnt <= filt_cnt - FW'(1);
            end
        end
    end

    assign fall = filt_clk_q & ~filt_clk;

    // frame state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            wdog      <= '0;
            key_en    <= 1'b0;
            key_data  <= 8'h00;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            wdog      <= wdog_nxt;
            key_en    <= key_en_nxt;
            key_data  <= key_data_nxt;
            frame_err <= frame_err_nxt;
`ifdef PS2_PARITY_CHECK_EN
            par       <= par_nxt;
`endif
        end
    end

    // next-state, datapath and pulse decode; a falling edge takes priority over the timeout
    always_comb begin
        state_nxt     = state;
        bitcnt_nxt    = bitcnt;
        shreg_nxt     = shreg;
        wdog_nxt      = '0;
        key_en_nxt    = 1'b0;
        key_data_nxt  = key_data;
        frame_err_nxt = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_nxt       = par;
`endif
        if (state != IDLE && !fall)
            wdog_nxt = wdog + WW'(1);

        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!dat_sync) begin
                        state_nxt  = DATA;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shreg_nxt  = {dat_sync, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_nxt = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_nxt = dat_sync;
`endif
                    state_nxt = STOP;
                end
                STOP: begin
                    if (stop_ok) begin
                        key_data_nxt = shreg;
                        key_en_nxt   = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && wdog == WDOG_LAST) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
            wdog_nxt      = '0;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Testbench for ps2_rx: table of frames plus hand sequences (bad start,
// clock glitch, watchdog timeout, mid-frame reset) and random frames
// checked against a rule-level frame model.

module tb_ps2_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 30;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       key_en;
    logic [7:0] key_data;
    logic       frame_err;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_en(key_en), .key_data(key_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // pulse monitor, sampled away from the active edge
    int n_en = 0, n_err = 0, n_both = 0, last_err_cyc = 0;
    always @(negedge clk) begin
        if (key_en) n_en = n_en + 1;
        if (frame_err) begin
            n_err = n_err + 1;
            last_err_cyc = cyc;
        end
        if (key_en && frame_err) n_both = n_both + 1;
    end

    int checks = 0, errors = 0;
    int last_fall_cyc = 0;
    logic [7:0] exp_data = 8'h00;

    typedef struct {
        string      name;
        logic [7:0] d;
        bit         par;
        bit         stop;
        int         exp_en;
        int         exp_err;
        logic [7:0] exp_d;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
        ps2_dat = 1'b1;
    endtask

    // frame rules: start 0, stop 1, and (when checked) odd parity over data+par
    function automatic bit model_good(input logic [7:0] d, input bit par, input bit stop);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(par);
        return stop && (!PAR_CHK || (ones % 2 == 1));
    endfunction

    task automatic run_frame(input string name, input logic [7:0] d, input bit par,
                             input bit stop, input int exp_en, input int exp_err,
                             input logic [7:0] exp_d);
        int e0, r0;
        logic [10:0] bits;
        e0 = n_en;
        r0 = n_err;
        bits = {stop, par, d, 1'b0};
        send_bits(bits, 11);
        check($sformatf("%s_key_en", name), n_en - e0, exp_en);
        check($sformatf("%s_frame_err", name), n_err - r0, exp_err);
        check($sformatf("%s_key_data", name), int'(key_data), int'(exp_d));
    endtask

    vec_t vecs[10];

    initial begin
        int e0, r0, lat;
        bit seen;
        logic [10:0] bits;
        logic [7:0] rd;
        bit rp, rs, good;

        vecs[0] = '{"v1c",   8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[1] = '{"ve0",   8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
        vecs[2] = '{"v75",   8'h75, 1'b0, 1'b1, 1, 0, 8'h75};
        vecs[3] = '{"vf0bp", 8'hF0, 1'b0, 1'b1, PAR_CHK ? 0 : 1, PAR_CHK ? 1 : 0,
                    PAR_CHK ? 8'h75 : 8'hF0};
        vecs[4] = '{"vstop", 8'h1C, 1'b1, 1'b0, 0, 1, PAR_CHK ? 8'h75 : 8'hF0};
        vecs[5] = '{"vf0",   8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
        vecs[6] = '{"v00",   8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
        vecs[7] = '{"vff",   8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};
        vecs[8] = '{"va5bp", 8'hA5, 1'b0, 1'b1, PAR_CHK ? 0 : 1, PAR_CHK ? 1 : 0,
                    PAR_CHK ? 8'hFF : 8'hA5};
        vecs[9] = '{"v3c",   8'h3C, 1'b1, 1'b1, 1, 0, 8'h3C};

        reset = 1'b1;
        wait_cyc(5);
        check("rst_key_en", int'(key_en), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_key_data", int'(key_data), 0);
        reset = 1'b0;
        wait_cyc(20);

        // table frames, sent back to back
        for (int i = 0; i < 10; i++)
            run_frame(vecs[i].name, vecs[i].d, vecs[i].par, vecs[i].stop,
                      vecs[i].exp_en, vecs[i].exp_err, vecs[i].exp_d);
        exp_data = 8'h3C;
        wait_cyc(10);

        // start bit of 1 while idle
        e0 = n_en; r0 = n_err;
        ps2_bit(1'b1);
        wait_cyc(5);
        check("badstart_frame_err", n_err - r0, 1);
        check("badstart_key_en", n_en - e0, 0);

        // short low glitch on ps2_clk while idle
        e0 = n_en; r0 = n_err;
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check("glitch_key_en", n_en - e0, 0);
        check("glitch_frame_err", n_err - r0, 0);
        run_frame("postglitch", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C);
        exp_data = 8'h1C;

        // start plus five data bits, then the clock stalls high
        e0 = n_en; r0 = n_err;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        send_bits(bits, 6);
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC + 100 && !seen; i++) begin
            wait_cyc(1);
            if (n_err != r0) seen = 1'b1;
        end
        check("timeout_frame_err", n_err - r0, 1);
        check("timeout_key_en", n_en - e0, 0);
        check("timeout_key_data", int'(key_data), int'(exp_data));
        lat = last_err_cyc - last_fall_cyc;
        checks++;
        if (!seen || lat < TIMEOUT_CYC + 9 || lat > TIMEOUT_CYC + 13) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles (seen=%0d), required %0d..%0d",
                     lat, seen, TIMEOUT_CYC + 9, TIMEOUT_CYC + 13);
        end
        wait_cyc(10);
        run_frame("posttimeout", 8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0);
        exp_data = 8'hF0;

        // reset after the 4th data bit, then a full frame
        e0 = n_en; r0 = n_err;
        bits = {1'b1, 1'b0, 8'h1C, 1'b0};
        send_bits(bits, 5);
        reset = 1'b1;
        wait_cyc(2);
        check("midrst_key_en", int'(key_en), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_key_data", int'(key_data), 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(TIMEOUT_CYC + 20);
        check("midrst_no_en", n_en - e0, 0);
        check("midrst_no_err", n_err - r0, 0);
        run_frame("postrst", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C);
        exp_data = 8'h1C;

        // random frames with random gaps against the rule model
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 7) != 0);
            good = model_good(rd, rp, rs);
            if (good) exp_data = rd;
            run_frame($sformatf("rnd%0d", i), rd, rp, rs, good ? 1 : 0, good ? 0 : 1, exp_data);
            wait_cyc($urandom_range(0, 40));
        end

        check("en_err_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
